// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared board geometry, game status codes and scanner state encoding
//
// Contents:
//   BOARD_ROWS, BOARD_COLS  board geometry (4x4)
//   GS_*                    game status codes driven by the game circuit
//   scan_state_t            display scanner FSM states
//   cell_index()            flat cell index, row*BOARD_COLS+col (row 0 = bottom)
package connect4_pkg;

  localparam int BOARD_ROWS = 4;
  localparam int BOARD_COLS = 4;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_P1_WIN  = 2'b01;
  localparam logic [1:0] GS_P2_WIN  = 2'b10;
  localparam logic [1:0] GS_DRAW    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LIT   = 2'd2,
    ST_BLANK = 2'd3
  } scan_state_t;

  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return 4'(int'(row) * BOARD_COLS + int'(col));
  endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// rtl/scan_tick_counter.sv - modulo-N tick counter with clear, enable and terminal count
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   clear  in   synchronous clear to 0 (wins over en)
//   en     in   advance one step; wraps to 0 after N-1
//   tc     out  high while the count sits at N-1
module scan_tick_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  // N=1 still needs one flop; it simply stays at 0 with tc permanently high.
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/board_display_scanner.sv
// rtl/board_display_scanner.sv - row-multiplexed bicolour 4x4 LED scanner for the game board
//
// Optional feature macro: BOARD_SCAN_CURSOR_EN (drop-column cursor overlay on the top row).
//
// Ports:
//   clk               in   system clock
//   reset             in   asynchronous active-low reset
//   enable            in   scan enable; 0 blanks the display and parks in IDLE
//   in_gameboard      in   [15:0] cell occupied flags, bit = row*4+col, row 0 = bottom
//   in_players_cells  in   [15:0] cell owner, 0 = player1 (red), 1 = player2 (green)
//   in_game_status    in   [1:0]  00 playing, 01 p1 won, 10 p2 won, 11 draw
//   in_column         in   [3:0]  cursor column, 0-3 valid (cursor build only)
//   player_turn       in   cursor colour, 0 red / 1 green (cursor build only)
//   row_sel           out  [3:0]  one-hot active-high row drive
//   col_red           out  [3:0]  red column drive for the active row
//   col_green         out  [3:0]  green column drive for the active row
//   frame_done        out  one-cycle pulse as row 3 leaves its lit period
module board_display_scanner
  import connect4_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] in_gameboard,
  input  logic [15:0] in_players_cells,
  input  logic [1:0]  in_game_status,
`ifdef BOARD_SCAN_CURSOR_EN
  input  logic [3:0]  in_column,
  input  logic        player_turn,
`endif
  output logic [3:0]  row_sel,
  output logic [3:0]  col_red,
  output logic [3:0]  col_green,
  output logic        frame_done
);

  localparam logic [1:0] LAST_ROW = 2'(BOARD_ROWS - 1);

  scan_state_t state, state_d;
  logic [1:0]  row, row_d;

  logic lit_tc, blank_tc, blink_tc;
  logic frame_end;
  logic blink_phase;

  // Frame-coherent snapshot, refreshed only in LOAD.
  logic [15:0] snap_occ;
  logic [15:0] snap_own;
  logic [1:0]  snap_status;
  logic        snap_phase;
`ifdef BOARD_SCAN_CURSOR_EN
  logic [3:0]  snap_col;
  logic        snap_turn;
`endif

  logic [3:0] red_d, green_d;

  // Last lit cycle of row 3 while still enabled.
  assign frame_end = enable && (state == ST_LIT) && (row == LAST_ROW) && lit_tc;

  scan_tick_counter #(.N(SCAN_DIV)) u_lit_cnt (
    .clk   (clk),
    .reset (reset),
    .clear ((state != ST_LIT) || !enable),
    .en    (1'b1),
    .tc    (lit_tc)
  );

  scan_tick_counter #(.N(BLANK_CYCLES)) u_blank_cnt (
    .clk   (clk),
    .reset (reset),
    .clear ((state != ST_BLANK) || !enable),
    .en    (1'b1),
    .tc    (blank_tc)
  );

  // Never cleared except by reset: blink rhythm survives enable drops.
  scan_tick_counter #(.N(BLINK_FRAMES)) u_blink_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (frame_end),
    .tc    (blink_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      row   <= '0;
    end else begin
      state <= state_d;
      row   <= row_d;
    end
  end

  always_comb begin
    state_d = state;
    row_d   = row;
    if (!enable) begin
      state_d = ST_IDLE;
      row_d   = '0;
    end else begin
      case (state)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          state_d = ST_LIT;
          row_d   = '0;
        end
        ST_LIT: begin
          if (lit_tc) state_d = ST_BLANK;
        end
        ST_BLANK: begin
          if (blank_tc) begin
            if (row == LAST_ROW) begin
              row_d   = '0;
              state_d = ST_LOAD;
            end else begin
              row_d   = row + 2'd1;
              state_d = ST_LIT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_phase <= 1'b0;
    end else if (frame_end && blink_tc) begin
      blink_phase <= ~blink_phase;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_occ    <= '0;
      snap_own    <= '0;
      snap_status <= GS_PLAYING;
      snap_phase  <= 1'b0;
`ifdef BOARD_SCAN_CURSOR_EN
      snap_col    <= '0;
      snap_turn   <= 1'b0;
`endif
    end else if (state == ST_LOAD) begin
      snap_occ    <= in_gameboard;
      snap_own    <= in_players_cells;
      snap_status <= in_game_status;
      snap_phase  <= blink_phase;
`ifdef BOARD_SCAN_CURSOR_EN
      snap_col    <= in_column;
      snap_turn   <= player_turn;
`endif
    end
  end

  // Column pattern for the current row, with winner blinking applied.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    for (int c = 0; c < BOARD_COLS; c++) begin
      red_d[c]   = snap_occ[cell_index(row, 2'(c))] & ~snap_own[cell_index(row, 2'(c))];
      green_d[c] = snap_occ[cell_index(row, 2'(c))] &  snap_own[cell_index(row, 2'(c))];
    end
    if (snap_phase) begin
      case (snap_status)
        GS_P1_WIN: red_d = '0;
        GS_P2_WIN: green_d = '0;
        GS_DRAW: begin
          red_d   = '0;
          green_d = '0;
        end
        default: ;
      endcase
    end
`ifdef BOARD_SCAN_CURSOR_EN
    // Cursor only marks an empty top-row cell, and blinks with the phase.
    if ((snap_status == GS_PLAYING) && !snap_phase && (row == LAST_ROW) &&
        (snap_col[3:2] == 2'b00) && !snap_occ[cell_index(LAST_ROW, snap_col[1:0])]) begin
      if (snap_turn) green_d[snap_col[1:0]] = 1'b1;
      else           red_d[snap_col[1:0]]   = 1'b1;
    end
`endif
  end

  // Output flops lag the state register by one cycle; gating on enable makes
  // an enable drop blank the pins on the same edge the FSM returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sel    <= '0;
      col_red    <= '0;
      col_green  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (enable && (state == ST_LIT)) begin
        row_sel   <= 4'b0001 << row;
        col_red   <= red_d;
        col_green <= green_d;
      end else begin
        row_sel   <= '0;
        col_red   <= '0;
        col_green <= '0;
      end
    end
  end

endmodule

// File: tb/tb_board_display_scanner.sv
// tb/tb_board_display_scanner.sv - self-checking bench for board_display_scanner (SCAN_DIV=4, BLANK_CYCLES=2, BLINK_FRAMES=2)
module tb_board_display_scanner;

  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = 4 * SLOT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] gb, pc;
  logic [1:0]  gs;
`ifdef BOARD_SCAN_CURSOR_EN
  logic [3:0]  cur_col;
  logic        cur_turn;
  logic [3:0]  s_col;
  logic        s_turn;
`endif
  logic [3:0]  row_sel, col_red, col_green;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Model state: k = posedges since enable was first seen high after IDLE.
  int          k;
  int          frames;
  logic [15:0] s_b, s_o;
  logic [1:0]  s_s;
  logic        s_ph;

  board_display_scanner #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .in_gameboard     (gb),
    .in_players_cells (pc),
    .in_game_status   (gs),
`ifdef BOARD_SCAN_CURSOR_EN
    .in_column        (cur_col),
    .player_turn      (cur_turn),
`endif
    .row_sel          (row_sel),
    .col_red          (col_red),
    .col_green        (col_green),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (k=%0d)", name, act, exp, k);
    end
  endtask

  // Timeline model: a frame is FRAME cycles = one LOAD + 4 rows of (SD lit + BC dark);
  // pins show the state one cycle late.
  function automatic logic [12:0] model_out(input logic en_e);
    logic [3:0] rs, r, g;
    logic       fd, hide_r, hide_g, occ, own;
    int         m, rr, w;
    rs = '0; r = '0; g = '0; fd = 1'b0;
    if (en_e && k >= 2) begin
      m = (k - 2) % FRAME;
      if (m >= 1) begin
        rr = (m - 1) / SLOT;
        w  = (m - 1) % SLOT;
        if (w < SD) begin
          rs = 4'(1 << rr);
          hide_r = s_ph && (s_s == 2'd1 || s_s == 2'd3);
          hide_g = s_ph && (s_s == 2'd2 || s_s == 2'd3);
          for (int c = 0; c < 4; c++) begin
            occ = s_b[rr * 4 + c];
            own = s_o[rr * 4 + c];
            if (occ && !own && !hide_r) r[c] = 1'b1;
            if (occ && own && !hide_g)  g[c] = 1'b1;
          end
`ifdef BOARD_SCAN_CURSOR_EN
          if (s_s == 2'd0 && !s_ph && rr == 3 && s_col < 4 && !s_b[12 + int'(s_col)]) begin
            if (s_turn) g[s_col] = 1'b1;
            else        r[s_col] = 1'b1;
          end
`endif
        end
      end
    end
    if (en_e && k >= 1 && (k - 1) % FRAME == FRAME - 2) fd = 1'b1;
    return {fd, rs, r, g};
  endfunction

  task automatic step();
    logic        en_e;
    logic [12:0] exp;
    en_e = enable;
    if (en_e) k++;
    else      k = 0;
    if (en_e && k >= 2 && (k - 2) % FRAME == 0) begin
      s_b  = gb;
      s_o  = pc;
      s_s  = gs;
      s_ph = ((frames / BF) % 2) == 1;
`ifdef BOARD_SCAN_CURSOR_EN
      s_col  = cur_col;
      s_turn = cur_turn;
`endif
    end
    @(posedge clk);
    #1;
    exp = model_out(en_e);
    check("model", {19'd0, frame_done, row_sel, col_red, col_green}, {19'd0, exp});
    if (exp[12]) frames++;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs", {19'd0, frame_done, row_sel, col_red, col_green}, 32'd0);
    @(negedge clk);
    k = 0; frames = 0; s_b = '0; s_o = '0; s_s = '0; s_ph = 1'b0;
`ifdef BOARD_SCAN_CURSOR_EN
    s_col = '0; s_turn = 1'b0;
`endif
    reset = 1'b1;
  endtask

  typedef struct {
    logic [15:0] b;
    logic [15:0] o;
    logic [1:0]  s;
    logic [15:0] er;
    logic [15:0] eg;
  } vec_t;

  vec_t        tbl[6];
  logic [3:0]  rs_exp[9];
  logic [4:0]  red_on;

  initial begin
    reset = 1'b0; enable = 1'b0; gb = '0; pc = '0; gs = '0;
`ifdef BOARD_SCAN_CURSOR_EN
    cur_col = 4'd7; cur_turn = 1'b0;
`endif
    k = 0; frames = 0;

    tbl[0] = '{16'h0003, 16'h0002, 2'b00, 16'h0001, 16'h0002};
    tbl[1] = '{16'h1001, 16'h0000, 2'b00, 16'h1001, 16'h0000};
    tbl[2] = '{16'h0011, 16'h0010, 2'b01, 16'h0001, 16'h0010};
    tbl[3] = '{16'hFFFF, 16'hAAAA, 2'b11, 16'h5555, 16'hAAAA};
    tbl[4] = '{16'hF0F0, 16'hFF00, 2'b10, 16'h00F0, 16'hF000};
    tbl[5] = '{16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000};

    // Frame 0 row contents, sampled mid-lit for each row.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      gb = tbl[i].b; pc = tbl[i].o; gs = tbl[i].s; enable = 1'b1;
      for (int c = 1; c <= 24; c++) begin
        step();
        if (c % SLOT == 4) begin
          check("tbl_row_sel", {28'd0, row_sel}, 32'(4'b0001 << ((c - 4) / SLOT)));
          check("tbl_col_red", {28'd0, col_red}, {28'd0, tbl[i].er[4 * ((c - 4) / SLOT) +: 4]});
          check("tbl_col_green", {28'd0, col_green}, {28'd0, tbl[i].eg[4 * ((c - 4) / SLOT) +: 4]});
        end
      end
    end

    // Start-up timing: LOAD, row 0 for 4, dark for 2, then row 1; frame_done every 25.
    rs_exp = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2};
    do_reset();
    gb = 16'h0003; pc = 16'h0002; gs = 2'b00; enable = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (c <= 9) check("startup_row_sel", {28'd0, row_sel}, {28'd0, rs_exp[c - 1]});
      if (c == 23 || c == 24 || c == 25 || c == 48 || c == 49)
        check("frame_done", {31'd0, frame_done}, {31'd0, (c == 24 || c == 49)});
    end

    // Mid-frame input change is held off until the next LOAD.
    do_reset();
    gb = 16'h0001; pc = 16'h0000; gs = 2'b00; enable = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 16) gb = 16'h1001;
      if (c == 22) check("midframe_hold", {24'd0, row_sel, col_red}, {24'd0, 4'h8, 4'h0});
      if (c == 47) check("midframe_next", {24'd0, row_sel, col_red}, {24'd0, 4'h8, 4'h1});
    end

    // Player1 win: red cell blinks two frames on / two off, green steady.
    red_on = 5'b10011;
    do_reset();
    gb = 16'h0011; pc = 16'h0010; gs = 2'b01; enable = 1'b1;
    for (int c = 1; c <= 4 * FRAME + 12; c++) begin
      step();
      if (c % FRAME == 4) check("blink_red", {31'd0, col_red[0]}, {31'd0, red_on[c / FRAME]});
      if (c % FRAME == 10) check("blink_green", {28'd0, col_green}, 32'h1);
    end

    // Enable drop mid row 1, then restart at row 0.
    do_reset();
    gb = 16'h0003; pc = 16'h0002; gs = 2'b00; enable = 1'b1;
    for (int c = 1; c <= 10; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("enable_drop", {20'd0, row_sel, col_red, col_green}, 32'd0);
    end
    enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 4) check("reenable_row0", {20'd0, row_sel, col_red, col_green}, {20'd0, 4'h1, 4'h1, 4'h2});
    end

`ifdef BOARD_SCAN_CURSOR_EN
    // Cursor overlay on an empty board, blinking with the phase.
    do_reset();
    gb = '0; pc = '0; gs = 2'b00; cur_col = 4'd2; cur_turn = 1'b1; enable = 1'b1;
    for (int c = 1; c <= 2 * FRAME + 22; c++) begin
      step();
      if (c == 22) check("cursor_on", {24'd0, col_red, col_green}, {24'd0, 4'h0, 4'h4});
      if (c == 2 * FRAME + 22) check("cursor_blink_off", {24'd0, col_red, col_green}, 32'd0);
    end
    do_reset();
    gb = '0; pc = '0; gs = 2'b00; cur_col = 4'd5; cur_turn = 1'b1; enable = 1'b1;
    for (int c = 1; c <= 22; c++) step();
    check("cursor_out_of_range", {20'd0, row_sel, col_red, col_green}, {20'd0, 4'h8, 8'h00});
`endif

    // Randomized run against the timeline model, with occasional enable drops.
    do_reset();
    gb = 16'($urandom); pc = 16'($urandom); gs = 2'($urandom_range(0, 3)); enable = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      if ($urandom_range(0, 7) == 0) begin
        gb = 16'($urandom); pc = 16'($urandom); gs = 2'($urandom_range(0, 3));
`ifdef BOARD_SCAN_CURSOR_EN
        cur_col = 4'($urandom_range(0, 5)); cur_turn = 1'($urandom);
`endif
      end
      if (!enable) enable = 1'b1;
      else if ($urandom_range(0, 149) == 0) enable = 1'b0;
    end

    // Asynchronous reset clears the pins without waiting for a clock edge.
    do_reset();
    gb = 16'hFFFF; pc = 16'h0000; gs = 2'b00; enable = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    check("lit_before_async", {20'd0, row_sel, col_red, col_green}, {20'd0, 4'h1, 4'hF, 4'h0});
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {19'd0, frame_done, row_sel, col_red, col_green}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_display_scanner.md
Name: board_display_scanner

Overview:
- Reads the 16-cell game board and the player-ownership vector produced by the column-select/game circuit and drives a multiplexed 4x4 bicolour (red/green) LED matrix, one row at a time.
- It is the consumer end of the out_gameboard / out_players_cells / out_game_status interface.
- Adds inter-row blanking, a frame-coherent snapshot and winner blinking.

Parameters:
- SCAN_DIV, 1000: clk cycles a row stays lit (minimum 2).
- BLANK_CYCLES, 16: clk cycles with all rows off between rows (minimum 1).
- BLINK_FRAMES, 64: completed frames per blink-phase toggle (minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scan enable; 0 blanks display
- in_gameboard  in  16  cell occupied flags; bit index = row*4+col, row 0 = bottom
- in_players_cells  in  16  cell owner; 0 = player1 (red), 1 = player2 (green)
- in_game_status  in  2  00 playing, 01 player1 won, 10 player2 won, 11 draw
- row_sel  out  4  one-hot active-high row drive
- col_red  out  4  red column drive for the active row
- col_green  out  4  green column drive for the active row
- frame_done  out  1  one-cycle pulse after row 3 finishes its lit period

Behaviour:
- Reset (reset=0, async): state=IDLE; row, prescaler, frame counter and blink phase = 0; snapshot registers = 0. Outputs row_sel=0, col_red=0, col_green=0, frame_done=0.
- FSM states: IDLE, LOAD, LIT, BLANK.
- IDLE: outputs 0. enable=1 -> LOAD next cycle.
- LOAD (1 cycle, entered only when starting row 0):
  - Captures in_gameboard, in_players_cells and in_game_status into snapshot registers.
  - row=0, prescaler=0; -> LIT.
  - Input changes mid-frame are not visible until the next LOAD.
- LIT:
  - row_sel = 1<<row.
  - Columns come from the snapshot cell i=row*4+c:
    - red[c] = occ[i] & ~own[i]
    - green[c] = occ[i] & own[i]
  - Stays SCAN_DIV cycles (prescaler 0..SCAN_DIV-1), then -> BLANK with prescaler cleared.
  - When row=3 ends, frame_done pulses in the cycle BLANK is entered.
- BLANK: all outputs 0 for BLANK_CYCLES cycles. Then:
  - row<3: row++ and -> LIT.
  - row=3: row wraps to 0 and -> LOAD.
- Registered outputs: column/row values appear in the cycle after the state register enters LIT, i.e. 1-cycle latency from state to pins.
- Blink:
  - Frame counter increments on every frame_done. At BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
  - Blink phase takes effect only at LOAD (captured with the snapshot).
  - Phase=1 suppresses lit cells according to the snapshot status:
    - 01: suppress red cells.
    - 10: suppress green cells.
    - 11: suppress all cells.
    - 00: no blinking. Phase keeps toggling but is ignored.
- enable falls in any state: next cycle -> IDLE, outputs 0, row and prescaler cleared, frame counter and blink phase held.
- Re-enable always restarts at LOAD/row 0.
- Row and column outputs are never non-zero in the same cycle as a row change. BLANK guarantees this.
- Async reset asserted mid-row: outputs 0 immediately (combinational path from reset through the output flops' async clear).
- Counter widths: $clog2 of the respective parameter. No arithmetic overflow is possible.

Optional Feature:
- Macro: BOARD_SCAN_CURSOR_EN.
- When defined:
  - Extra inputs: in_column (4 bits, 0-3 valid) and player_turn (1 bit).
  - While snapshot status=00, the top-row cell (row 3, col in_column) is overlaid in player_turn's colour (0 red, 1 green), but only if that cell is unoccupied.
  - The overlay is lit only when blink phase=0.
  - in_column>3 produces no overlay.
  - in_column and player_turn are captured at LOAD like other inputs.
- When undefined: ports absent, no overlay logic, behaviour as above.

Decomposition:
- Shared package connect4_pkg:
  - BOARD_ROWS=4, BOARD_COLS=4.
  - Game status codes GS_PLAYING/GS_P1_WIN/GS_P2_WIN/GS_DRAW.
  - Cell-index function row*BOARD_COLS+col.
  - FSM state encoding.
- One sub-module: scan_tick_counter. It is a parameterised modulo-N counter with clear, enable and a terminal-count output, instantiated for the LIT and BLANK durations and for BLINK_FRAMES.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2, BLINK_FRAMES=2):
- Reset, then release with enable=1 -> all outputs 0 during reset; LOAD 1 cycle; row_sel=0001 held for exactly 4 cycles, then 0000 for 2 cycles, then 0010.
- Board 0x0003, owners 0x0002, status 00 -> during row 0: col_red=0001, col_green=0010; rows 1-3: columns 0000. frame_done pulses once every 4*(4+2)+1=25 cycles.
- Change in_gameboard from 0x0001 to 0x1001 while row 2 is lit -> row 3 stays dark this frame and shows col_red=0001 in the next frame.
- Status 01, board 0x0011, owners 0x0010 -> frames alternate in pairs: red cell (row 0 col 0) on for 2 frames, off for 2; green cell (row 1 col 0) steady.
- Drop enable mid-LIT of row 1 -> next cycle all outputs 0 and state IDLE. Re-enable -> row 0 shown first after LOAD.
- With BOARD_SCAN_CURSOR_EN, status 00, in_column=2, player_turn=1, empty board -> row 3 shows col_green=0100 in phase 0 and 0000 in phase 1. With in_column=5 there is no overlay.
